rsv_demux_sched: RTL and testbench
==================================

// Module: rsv_demux_sched
// PURPOSE
//  Scheduler/sequencer for the 1-to-5 reservation demux in the router datapath.
//  Buffers incoming flits tagged with a destination port, presents the head flit on the demux
//  data input with the matching 3-bit select, and runs a valid/ready handshake per output.
//  Drops and counts flits with an illegal port; flags head-of-line stalls.
//  Sits between the route-compute stage and the demux1to5 instance.
// PARAMETERS
//  WIDTH      1    flit width; equals the demux WIDTH
//  DEPTH      2    FIFO entries; power of 2, >=2
//  STALL_MAX  15   head-stall cycles before hol_stall asserts; 1..255
// PORTS
//  clk        in   1        clock; all logic on rising edge
//  rst_n      in   1        synchronous, active-low reset
//  in_valid   in   1        flit offered
//  in_ready   out  1        FIFO can accept; equals !full
//  in_data    in   WIDTH    flit payload
//  in_port    in   3        destination: 0..4 map to out1..out5; 5..7 illegal
//  dmx_din    out  WIDTH    to demux din; head payload, 0 when empty
//  dmx_sel    out  3        to demux sel; head port, 3'b000 when empty
//  out_valid  out  5        one-hot; bit p set when head is valid for port p
//  out_ready  in   5        per-port downstream ready
//  drop_pulse out  1        one-cycle pulse: illegal-port flit discarded
//  drop_cnt   out  8        saturating count of dropped flits
//  hol_stall  out  1        head blocked >= STALL_MAX cycles
//  busy       out  1        FIFO non-empty
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): FIFO emptied and pointers zeroed.
//   All outputs 0 except in_ready=1: out_valid=0, dmx_sel=0, dmx_din=0,
//   drop_pulse=0, drop_cnt=0, hol_stall=0, busy=0.
//   Mid-operation reset discards buffered flits without any output transfer.
//  Accept: on in_valid & in_ready.
//   If in_port<=4, write {in_port,in_data} at the tail.
//   If in_port>=5, do not write; drop_pulse=1 the next cycle; drop_cnt+1, saturating at 255.
//  Latency: a flit accepted at edge N is visible at the head after edge N (registered FIFO,
//   no bypass). In-to-demux latency is 1 cycle.
//  Present: when non-empty, dmx_sel=head.port, dmx_din=head.data, out_valid=1<<head.port.
//   These are combinational from head storage; no other out_valid bit is ever set.
//  Pop: on out_valid[p] & out_ready[p] for the head port. out_ready bits of other ports are ignored.
//   Strict FIFO order; head-of-line blocking is intended.
//  Full: in_ready=0. A push and pop in the same cycle is legal only when not full; count unchanged.
//  Empty: no pop. Push to an empty FIFO appears at the head the next cycle.
//  Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
//  Throughput: with DEPTH>=2 and out_ready held high, 1 flit/cycle is sustained.
//  Stall FSM, two states:
//   IDLE  -> WAIT  when non-empty and no pop.
//   WAIT  -> IDLE  on pop or empty.
//   WAIT counts stall cycles, saturating at STALL_MAX.
//   hol_stall=1 while WAIT and count==STALL_MAX. It clears in the cycle after the head pops.
//   A new head restarts the count from 0.
//  Drop counter: a drop and saturation in the same cycle leaves the count at 255;
//   drop_pulse still fires.
// STRUCTURE
//  Shared header (rsv_defs) holds:
//   NUM_PORTS=5, PORT_W=3, and PORT_OUT1..PORT_OUT5 = 3'd0..3'd4, matching the demux select map;
//   PORT_ILLEGAL_MIN=3'd5;
//   stall-FSM state encodings S_IDLE=1'b0, S_WAIT=1'b1.
//  One sub-module: rsv_sync_fifo (WIDTH+3 bits x DEPTH, push/pop/full/empty/head).
//  The scheduler logic stays in this module: drop path, one-hot decode, stall FSM, counters.
// TESTING
//  1. Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=1, out_valid=0,
//     drop_cnt=0, busy=0; nothing is written.
//  2. Routing: push port 0..4 with data 1..5 at 1/cycle, out_ready=5'h1F ->
//     out_valid=01,02,04,08,10 on consecutive cycles; dmx_sel=0..4; dmx_din=1..5; 1-cycle latency.
//  3. Backpressure: out_ready=0, push 3 flits, DEPTH=2 -> in_ready=0 after 2 accepts.
//     hol_stall rises exactly 15 cycles after the head appears.
//     Raising out_ready[head] pops it and clears hol_stall the next cycle.
//  4. Wrong-port ready: head port 3, out_ready=5'h17 -> no pop; out_ready=5'h08 -> pop.
//  5. Illegal port: push in_port=5,6,7 -> 3 drop_pulses, drop_cnt=3, FIFO empty.
//     260 drops -> drop_cnt=255.
//  6. Mid-traffic reset: full FIFO, assert rst_n=0 for 1 cycle -> busy=0, out_valid=0
//     the next cycle; the following push works normally.

Source files
------------

// File: rtl/rsv_demux_sched_pkg.sv
// Shared definitions for the reservation demux scheduler: port map, select encodings
// and stall-FSM state codes.
package rsv_demux_sched_pkg;

    localparam int NUM_PORTS = 5;
    localparam int PORT_W    = 3;

    typedef logic [PORT_W-1:0] port_t;

    // Must match the demux1to5 select map.
    localparam port_t PORT_OUT1        = 3'd0;
    localparam port_t PORT_OUT2        = 3'd1;
    localparam port_t PORT_OUT3        = 3'd2;
    localparam port_t PORT_OUT4        = 3'd3;
    localparam port_t PORT_OUT5        = 3'd4;
    localparam port_t PORT_ILLEGAL_MIN = 3'd5;

    localparam logic S_IDLE = 1'b0;
    localparam logic S_WAIT = 1'b1;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input port_t p);
        logic [NUM_PORTS-1:0] oh;
        oh = '0;
        case (p)
            PORT_OUT1: oh = 5'b00001;
            PORT_OUT2: oh = 5'b00010;
            PORT_OUT3: oh = 5'b00100;
            PORT_OUT4: oh = 5'b01000;
            PORT_OUT5: oh = 5'b10000;
            default:   oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/rsv_demux_sched_if.sv
// Flit-in / demux-out handshake bundle between route-compute, scheduler and demux.
interface rsv_demux_sched_if
    import rsv_demux_sched_pkg::*;
#(
    parameter int WIDTH = 1
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    port_t                in_port;
    logic [WIDTH-1:0]     dmx_din;
    port_t                dmx_sel;
    logic [NUM_PORTS-1:0] out_valid;
    logic [NUM_PORTS-1:0] out_ready;

    modport master (
        output in_valid, in_data, in_port, out_ready,
        input  in_ready, dmx_din, dmx_sel, out_valid
    );

    modport slave (
        input  in_valid, in_data, in_port, out_ready,
        output in_ready, dmx_din, dmx_sel, out_valid
    );

endinterface

// File: rtl/rsv_sync_fifo.sv
// Registered synchronous FIFO, no bypass: a push is visible at the head one edge later.
module rsv_sync_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [AW:0]             cnt_q, cnt_d;
    logic                    do_push;
    logic                    do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers are AW bits wide, so wrap modulo DEPTH falls out of the addition.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/rsv_demux_sched.sv
// Scheduler in front of demux1to5: buffers routed flits, drives select/data for the head
// flit, drops illegal-port flits and flags head-of-line stalls.
//
//  state  | meaning
//  S_IDLE | head absent, or present and not yet blocked for a cycle
//  S_WAIT | head blocked; stall_cnt counts blocked cycles up to STALL_MAX
module rsv_demux_sched
    import rsv_demux_sched_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int DEPTH     = 2,
    parameter int STALL_MAX = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rsv_demux_sched_if.slave     bus,
    output logic                 drop_pulse,
    output logic [7:0]           drop_cnt,
    output logic                 hol_stall,
    output logic                 busy
);

    localparam int FW = WIDTH + PORT_W;
    localparam logic [7:0] STALL_MAX_C = 8'(STALL_MAX);

    logic          fifo_full;
    logic          fifo_empty;
    logic [FW-1:0] fifo_head;
    port_t         head_port;
    logic [WIDTH-1:0] head_data;
    logic          accept;
    logic          legal;
    logic          push;
    logic          drop;
    logic          pop;

    logic          state_q, state_d;
    logic [7:0]    stall_cnt_q, stall_cnt_d;
    logic          drop_pulse_q, drop_pulse_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    assign legal  = (bus.in_port < PORT_ILLEGAL_MIN);
    assign accept = bus.in_valid & bus.in_ready;
    assign push   = accept & legal;
    assign drop   = accept & ~legal;

    rsv_sync_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({bus.in_port, bus.in_data}),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign head_port = fifo_head[FW-1:WIDTH];
    assign head_data = fifo_head[WIDTH-1:0];

    assign bus.in_ready  = ~fifo_full;
    assign bus.out_valid = fifo_empty ? '0 : port_onehot(head_port);
    assign bus.dmx_sel   = fifo_empty ? '0 : head_port;
    assign bus.dmx_din   = fifo_empty ? '0 : head_data;
    // Only the head port's ready can pop; other ready bits are masked by out_valid.
    assign pop           = |(bus.out_valid & bus.out_ready);
    assign busy          = ~fifo_empty;

    // Entering WAIT loads 1: the IDLE cycle that saw the blocked head is the first stall cycle.
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_IDLE) begin
            if (!fifo_empty && !pop) begin
                state_d     = S_WAIT;
                stall_cnt_d = 8'd1;
            end
        end else begin
            if (pop || fifo_empty) begin
                state_d     = S_IDLE;
                stall_cnt_d = '0;
            end else if (stall_cnt_q != STALL_MAX_C) begin
                stall_cnt_d = stall_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        drop_pulse_d = drop;
        drop_cnt_d   = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            stall_cnt_q  <= '0;
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            stall_cnt_q  <= stall_cnt_d;
            drop_pulse_q <= drop_pulse_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign hol_stall  = (state_q == S_WAIT) && (stall_cnt_q == STALL_MAX_C);
    assign drop_pulse = drop_pulse_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_rsv_demux_sched.sv
// Directed bench for rsv_demux_sched (WIDTH=4, DEPTH=2, STALL_MAX=15).
module tb_rsv_demux_sched;
    import rsv_demux_sched_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       drop_pulse;
    logic [7:0] drop_cnt;
    logic       hol_stall;
    logic       busy;
    int         n_cmp;
    int         n_bad;

    rsv_demux_sched_if #(.WIDTH(4)) bus ();

    rsv_demux_sched #(
        .WIDTH     (4),
        .DEPTH     (2),
        .STALL_MAX (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .drop_pulse (drop_pulse),
        .drop_cnt   (drop_cnt),
        .hol_stall  (hol_stall),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] p, input logic [3:0] d);
        bus.in_valid = v;
        bus.in_port  = p;
        bus.in_data  = d;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.out_ready = 5'h00;
        drive(1'b1, 3'd0, 4'd1);

        // 1. reset held with in_valid high
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        chk("rst_sel", 32'(bus.dmx_sel), 32'd0);
        chk("rst_din", 32'(bus.dmx_din), 32'd0);
        chk("rst_hol", 32'(hol_stall), 32'd0);
        chk("rst_drop_pulse", 32'(drop_pulse), 32'd0);
        drive(1'b0, 3'd0, 4'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", 32'(busy), 32'd0);

        // 2. routing at one flit per cycle
        bus.out_ready = 5'h1F;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'(i), 4'(i + 1));
            step();
            chk("route_valid", 32'(bus.out_valid), 32'd1 << i);
            chk("route_sel", 32'(bus.dmx_sel), 32'(i));
            chk("route_din", 32'(bus.dmx_din), 32'(i + 1));
            chk("route_in_ready", 32'(bus.in_ready), 32'd1);
        end
        drive(1'b0, 3'd0, 4'd0);
        step();
        chk("route_drained", 32'(busy), 32'd0);
        chk("route_drained_valid", 32'(bus.out_valid), 32'd0);

        // 3. backpressure and head-of-line stall
        bus.out_ready = 5'h00;
        drive(1'b1, 3'd2, 4'd3);
        step();
        chk("bp_head_valid", 32'(bus.out_valid), 32'h04);
        chk("bp_ready_1", 32'(bus.in_ready), 32'd1);
        chk("bp_hol_0", 32'(hol_stall), 32'd0);
        drive(1'b1, 3'd1, 4'd5);
        step();
        chk("bp_full", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 3'd4, 4'd6);
        for (int k = 2; k <= 15; k++) begin
            step();
            if (k == 14) chk("bp_hol_k14", 32'(hol_stall), 32'd0);
            if (k == 15) chk("bp_hol_k15", 32'(hol_stall), 32'd1);
        end
        chk("bp_still_full", 32'(bus.in_ready), 32'd0);
        chk("bp_still_head", 32'(bus.out_valid), 32'h04);
        bus.out_ready = 5'h04;
        step();
        chk("bp_pop_hol", 32'(hol_stall), 32'd0);
        chk("bp_next_head", 32'(bus.out_valid), 32'h02);
        chk("bp_next_din", 32'(bus.dmx_din), 32'd5);
        drive(1'b0, 3'd0, 4'd0);
        bus.out_ready = 5'h1F;
        step();
        chk("bp_drained", 32'(busy), 32'd0);

        // 4. wrong-port ready does not pop
        bus.out_ready = 5'h00;
        drive(1'b1, 3'd3, 4'd7);
        step();
        drive(1'b0, 3'd0, 4'd0);
        bus.out_ready = 5'h17;
        step();
        chk("wp_valid", 32'(bus.out_valid), 32'h08);
        chk("wp_busy", 32'(busy), 32'd1);
        step();
        chk("wp_busy2", 32'(busy), 32'd1);
        bus.out_ready = 5'h08;
        step();
        chk("wp_popped", 32'(busy), 32'd0);
        chk("wp_valid_0", 32'(bus.out_valid), 32'd0);

        // 5. illegal ports and counter saturation
        bus.out_ready = 5'h00;
        for (int p = 5; p <= 7; p++) begin
            drive(1'b1, 3'(p), 4'd0);
            step();
            chk("ill_pulse", 32'(drop_pulse), 32'd1);
            chk("ill_cnt", 32'(drop_cnt), 32'(p - 4));
            chk("ill_busy", 32'(busy), 32'd0);
        end
        drive(1'b0, 3'd0, 4'd0);
        step();
        chk("ill_pulse_off", 32'(drop_pulse), 32'd0);
        chk("ill_cnt3", 32'(drop_cnt), 32'd3);
        drive(1'b1, 3'd6, 4'd0);
        for (int i = 0; i < 260; i++) begin
            step();
            if (i == 250) chk("sat_254", 32'(drop_cnt), 32'd254);
            if (i == 251) chk("sat_255", 32'(drop_cnt), 32'd255);
            if (i == 259) begin
                chk("sat_pulse", 32'(drop_pulse), 32'd1);
                chk("sat_hold", 32'(drop_cnt), 32'd255);
            end
        end
        drive(1'b0, 3'd0, 4'd0);
        step();
        chk("sat_final", 32'(drop_cnt), 32'd255);
        chk("sat_pulse_off", 32'(drop_pulse), 32'd0);
        chk("sat_empty", 32'(busy), 32'd0);

        // 6. reset with a full FIFO
        drive(1'b1, 3'd0, 4'd1);
        step();
        drive(1'b1, 3'd1, 4'd2);
        step();
        chk("mr_full", 32'(bus.in_ready), 32'd0);
        chk("mr_busy", 32'(busy), 32'd1);
        drive(1'b0, 3'd0, 4'd0);
        rst_n = 1'b0;
        step();
        chk("mr_busy0", 32'(busy), 32'd0);
        chk("mr_valid0", 32'(bus.out_valid), 32'd0);
        chk("mr_ready1", 32'(bus.in_ready), 32'd1);
        chk("mr_drop_cnt0", 32'(drop_cnt), 32'd0);
        chk("mr_sel0", 32'(bus.dmx_sel), 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 3'd4, 4'd9);
        step();
        drive(1'b0, 3'd0, 4'd0);
        chk("mr_push_valid", 32'(bus.out_valid), 32'h10);
        chk("mr_push_sel", 32'(bus.dmx_sel), 32'd4);
        chk("mr_push_din", 32'(bus.dmx_din), 32'd9);
        bus.out_ready = 5'h10;
        step();
        chk("mr_pop", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
